// File: rtl/sseg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture path: glyph table
// (common with the hex-to-7-segment encoder), digit FSM states and the
// "no digit enabled" anode pattern.
package sseg_scan_capture_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All anodes released: display blanked between digits.
    localparam logic [3:0] AN_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } scan_state_e;

    // True when exactly one anode is driven low.
    function automatic logic an_onehot_low(input logic [3:0] an_v);
        logic [3:0] on;
        on = ~an_v;
        return (on != 4'b0000) && ((on & (on - 4'd1)) == 4'b0000);
    endfunction

    // Position of the (single) low anode; only meaningful when one-hot-low.
    function automatic logic [1:0] an_index(input logic [3:0] an_v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!an_v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sseg_scan_capture_to_hex.sv
// Inverse of the hex-to-7-segment encoder: maps an active-low glyph back to
// its nibble. Patterns outside the table report valid=0 and nibble 0.
module sseg_to_hex
    import sseg_scan_capture_pkg::*;
(
    input  logic [6:0] sseg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    // Table search against the shared glyph constants.
    always_comb begin
        valid_o  = 1'b0;
        nibble_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sseg_i == GLYPH[i]) begin
                valid_o  = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Samples a multiplexed active-low seven-segment bus, waits for each digit
// to hold steady for SETTLE cycles, decodes it and assembles complete
// four-digit frames with glyph-error and value-changed flags.
module sseg_scan_capture
    import sseg_scan_capture_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        c_clk,
    input  logic        C_clr,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    output logic [15:0] value,
    output logic [3:0]  dp_lit,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        changed,
    output logic        an_err
);

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [3:0]  an_m_q, an_s_q, an_p_q;
    logic [6:0]  sseg_m_q, sseg_s_q, sseg_p_q;
    logic        dp_m_q, dp_s_q, dp_p_q;

    scan_state_e state_q;
    logic [7:0]  cnt_q;
    logic        an_err_q;

    logic [15:0] stage_val_q, stage_val_d;
    logic [3:0]  stage_dp_q, stage_dp_d;
    logic [3:0]  mask_q, mask_d;
    logic        bad_q, bad_d;
    logic        done_q, done_d;

    logic [15:0] value_q;
    logic [3:0]  dp_lit_q;
    logic        frame_valid_q, frame_err_q, changed_q;

    logic        chg, an_ok, an_idle, latch_now;
    logic [1:0]  idx;
    logic        dec_valid;
    logic [3:0]  dec_nib;

    // Two-stage synchronizers plus a copy of the previous synchronized sample.
    always_ff @(posedge c_clk or posedge C_clr) begin
        if (C_clr) begin
            an_m_q   <= '0; an_s_q   <= '0; an_p_q   <= '0;
            sseg_m_q <= '0; sseg_s_q <= '0; sseg_p_q <= '0;
            dp_m_q   <= 1'b0; dp_s_q <= 1'b0; dp_p_q <= 1'b0;
        end else begin
            an_m_q   <= an;       an_s_q   <= an_m_q;   an_p_q   <= an_s_q;
            sseg_m_q <= sseg;     sseg_s_q <= sseg_m_q; sseg_p_q <= sseg_s_q;
            dp_m_q   <= dp;       dp_s_q   <= dp_m_q;   dp_p_q   <= dp_s_q;
        end
    end

    assign chg       = {an_s_q, sseg_s_q, dp_s_q} != {an_p_q, sseg_p_q, dp_p_q};
    assign an_ok     = an_onehot_low(an_s_q);
    assign an_idle   = (an_s_q == AN_NONE);
    assign idx       = an_index(an_s_q);
    assign latch_now = (state_q == ST_SETTLE) && !chg && (cnt_q == SETTLE_M1);

    sseg_to_hex u_dec (
        .sseg_i   (sseg_s_q),
        .valid_o  (dec_valid),
        .nibble_o (dec_nib)
    );

    // Digit FSM: restart settling on every sample change, latch once stable.
    always_ff @(posedge c_clk or posedge C_clr) begin
        if (C_clr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            an_err_q <= 1'b0;
        end else begin
            an_err_q <= chg && !an_ok && !an_idle;
            if (chg) begin
                cnt_q   <= 8'd0;
                state_q <= an_ok ? ST_SETTLE : ST_IDLE;
            end else if (state_q == ST_SETTLE) begin
                if (cnt_q == SETTLE_M1) begin
                    state_q <= ST_HELD;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    // Staging next-state: a pending completion clears mask/error first,
    // then a latch writes its digit slot.
    always_comb begin
        stage_val_d = stage_val_q;
        stage_dp_d  = stage_dp_q;
        mask_d      = done_q ? 4'b0000 : mask_q;
        bad_d       = done_q ? 1'b0 : bad_q;
        if (latch_now) begin
            stage_val_d[{idx, 2'b00} +: 4] = dec_nib;
            stage_dp_d[idx]                = ~dp_s_q;
            mask_d[idx]                    = 1'b1;
            bad_d                          = bad_d | ~dec_valid;
        end
        done_d = latch_now && (mask_d == 4'b1111);
    end

    // Staging registers and frame-completion flag.
    always_ff @(posedge c_clk or posedge C_clr) begin
        if (C_clr) begin
            stage_val_q <= '0;
            stage_dp_q  <= '0;
            mask_q      <= '0;
            bad_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            stage_val_q <= stage_val_d;
            stage_dp_q  <= stage_dp_d;
            mask_q      <= mask_d;
            bad_q       <= bad_d;
            done_q      <= done_d;
        end
    end

    // Publish a completed frame; flags are held low outside the valid pulse.
    always_ff @(posedge c_clk or posedge C_clr) begin
        if (C_clr) begin
            value_q       <= '0;
            dp_lit_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            changed_q     <= 1'b0;
        end else begin
            frame_valid_q <= done_q;
            frame_err_q   <= done_q & bad_q;
            changed_q     <= done_q & (stage_val_q != value_q);
            if (done_q) begin
                value_q  <= stage_val_q;
                dp_lit_q <= stage_dp_q;
            end
        end
    end

    assign value       = value_q;
    assign dp_lit      = dp_lit_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign changed     = changed_q;
    assign an_err      = an_err_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture with SETTLE=4.
module tb_sseg_scan_capture;

    logic        c_clk = 1'b0;
    logic        C_clr = 1'b1;
    logic [3:0]  an    = 4'hF;
    logic [6:0]  sseg  = 7'h7F;
    logic        dp    = 1'b1;
    logic [15:0] value;
    logic [3:0]  dp_lit;
    logic        frame_valid, frame_err, changed, an_err;

    int n_chk  = 0;
    int n_pass = 0;
    int fv_cnt = 0;
    int ae_cnt = 0;
    int stray  = 0;
    logic last_err = 1'b0;
    logic last_chg = 1'b0;
    int fv0, ae0;

    sseg_scan_capture #(.SETTLE(4)) dut (
        .c_clk       (c_clk),
        .C_clr       (C_clr),
        .an          (an),
        .sseg        (sseg),
        .dp          (dp),
        .value       (value),
        .dp_lit      (dp_lit),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .changed     (changed),
        .an_err      (an_err)
    );

    always #5 c_clk = ~c_clk;

    always @(negedge c_clk) begin
        if (frame_valid) begin
            fv_cnt++;
            last_err = frame_err;
            last_chg = changed;
        end else if (frame_err || changed) begin
            stray++;
        end
        if (an_err) ae_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int dwell);
        an = a; sseg = s; dp = d;
        repeat (dwell) @(negedge c_clk);
    endtask

    task automatic frame(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                         input logic [6:0] g3, input logic [3:0] dpl, input int dwell);
        show(4'b1110, g0, ~dpl[0], dwell);
        show(4'b1101, g1, ~dpl[1], dwell);
        show(4'b1011, g2, ~dpl[2], dwell);
        show(4'b0111, g3, ~dpl[3], dwell);
        show(4'hF, 7'h7F, 1'b1, 10);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_value"},  32'(value), 32'h0);
        check({pfx, "_dp_lit"}, 32'(dp_lit), 32'h0);
        check({pfx, "_fv"},     32'(frame_valid), 32'h0);
        check({pfx, "_ferr"},   32'(frame_err), 32'h0);
        check({pfx, "_chg"},    32'(changed), 32'h0);
        check({pfx, "_anerr"},  32'(an_err), 32'h0);
    endtask

    initial begin
        logic [3:0] a;
        repeat (3) @(negedge c_clk);
        check_reset_outputs("rst");
        C_clr = 1'b0;
        repeat (5) @(negedge c_clk);

        // Basic frame 1234, dp on digit 2
        fv0 = fv_cnt;
        frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0100, 16);
        check("basic_fv", 32'(fv_cnt - fv0), 32'd1);
        check("basic_value", 32'(value), 32'h1234);
        check("basic_dp", 32'(dp_lit), 32'h4);
        check("basic_err", 32'(last_err), 32'h0);
        check("basic_chg", 32'(last_chg), 32'h1);

        // Same frame again: no change
        fv0 = fv_cnt;
        frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0100, 16);
        check("repeat_fv", 32'(fv_cnt - fv0), 32'd1);
        check("repeat_chg", 32'(last_chg), 32'h0);

        // 9999
        fv0 = fv_cnt;
        frame(7'h10, 7'h10, 7'h10, 7'h10, 4'b0000, 16);
        check("nines_fv", 32'(fv_cnt - fv0), 32'd1);
        check("nines_chg", 32'(last_chg), 32'h1);
        check("nines_value", 32'(value), 32'h9999);
        check("nines_dp", 32'(dp_lit), 32'h0);

        // Blank glyph on digit 1 -> nibble 0, frame_err
        fv0 = fv_cnt;
        frame(7'h19, 7'h7F, 7'h30, 7'h79, 4'b0000, 16);
        check("bad_fv", 32'(fv_cnt - fv0), 32'd1);
        check("bad_err", 32'(last_err), 32'h1);
        check("bad_value", 32'(value), 32'h1304);

        // Next clean frame clears the error
        fv0 = fv_cnt;
        frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0100, 16);
        check("clean_fv", 32'(fv_cnt - fv0), 32'd1);
        check("clean_err", 32'(last_err), 32'h0);
        check("clean_chg", 32'(last_chg), 32'h1);

        // Dwell 3 never latches
        fv0 = fv_cnt;
        ae0 = ae_cnt;
        for (int k = 0; k < 67; k++) begin
            a = ~(4'b0001 << (k % 4));
            show(a, 7'h30, 1'b1, 3);
        end
        show(4'hF, 7'h7F, 1'b1, 10);
        check("short_fv", 32'(fv_cnt - fv0), 32'd0);
        check("short_anerr", 32'(ae_cnt - ae0), 32'd0);

        // Dwell 5 is just enough
        fv0 = fv_cnt;
        show(4'b1110, 7'h12, 1'b1, 5);
        show(4'b1101, 7'h02, 1'b1, 5);
        show(4'b1011, 7'h78, 1'b1, 5);
        show(4'b0111, 7'h00, 1'b1, 5);
        show(4'b1110, 7'h12, 1'b1, 5);
        show(4'b1101, 7'h02, 1'b1, 5);
        show(4'b1011, 7'h78, 1'b1, 5);
        show(4'b0111, 7'h00, 1'b1, 5);
        show(4'hF, 7'h7F, 1'b1, 10);
        check("dwell5_fv", 32'(fv_cnt - fv0), 32'd2);
        check("dwell5_value", 32'(value), 32'h8765);

        // Two anodes low
        fv0 = fv_cnt;
        ae0 = ae_cnt;
        show(4'b1100, 7'h19, 1'b1, 10);
        show(4'hF, 7'h7F, 1'b1, 10);
        check("anerr_cnt", 32'(ae_cnt - ae0), 32'd1);
        check("anerr_fv", 32'(fv_cnt - fv0), 32'd0);

        // Reset after two digits discards them
        show(4'b1110, 7'h12, 1'b1, 16);
        show(4'b1101, 7'h02, 1'b1, 16);
        C_clr = 1'b1;
        #1;
        check_reset_outputs("midrst");
        an = 4'hF; sseg = 7'h7F; dp = 1'b1;
        repeat (3) @(negedge c_clk);
        C_clr = 1'b0;
        repeat (5) @(negedge c_clk);
        fv0 = fv_cnt;
        show(4'b1011, 7'h78, 1'b1, 16);
        show(4'b0111, 7'h00, 1'b1, 16);
        show(4'hF, 7'h7F, 1'b1, 10);
        check("midrst_partial_fv", 32'(fv_cnt - fv0), 32'd0);
        show(4'b1110, 7'h10, 1'b1, 16);
        show(4'b1101, 7'h08, 1'b1, 16);
        show(4'hF, 7'h7F, 1'b1, 10);
        check("midrst_fv", 32'(fv_cnt - fv0), 32'd1);
        check("midrst_value", 32'(value), 32'h87A9);
        check("midrst_chg", 32'(last_chg), 32'h1);

        check("flags_outside_valid", 32'(stray), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
